// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED PIO sequencer: modes, config register map and STATUS layout.
package led_seq_pkg;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int STAT_DIR_BIT   = 0;
  localparam int STAT_PEND_BIT  = 1;
  localparam int STAT_FRAME_LSB = 16;

endpackage

// File: rtl/led_tick_gen.sv
// Timebase for the sequencer: a prescaler producing base ticks and a period counter producing steps.
module led_tick_gen #(
  parameter int TICK_DIV = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [15:0] period,
  output logic        step
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic [15:0]   step_cnt;
  logic [15:0]   step_last;
  logic          tick;

  // A period of 0 behaves like 1: every tick is a step.
  assign step_last = (period == 16'd0) ? 16'd0 : period - 16'd1;
  assign tick      = enable && (presc == PRESC_MAX);
  assign step      = tick && (step_cnt == step_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      step_cnt <= '0;
    end else if (clear || !enable) begin
      presc    <= '0;
      step_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (step)
        step_cnt <= '0;
      else if (tick)
        step_cnt <= step_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/led_pio_sequencer.sv
// Autonomous LED frame sequencer; owns the LED PIO s1 port and pushes every frame change to it.
module led_pio_sequencer
  import led_seq_pkg::*;
#(
  parameter int         LED_WIDTH = 10,
  parameter int         TICK_DIV  = 5000000,
  parameter logic [1:0] PIO_ADDR  = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cfg_address,
  input  logic        cfg_chipselect,
  input  logic        cfg_write_n,
  input  logic [31:0] cfg_writedata,
  output logic [31:0] cfg_readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic        dbg_state
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_WRITE = 1'b1;

  logic                 enable;
  logic [1:0]           mode;
  logic [LED_WIDTH-1:0] pattern;
  logic [15:0]          period;
  logic [LED_WIDTH-1:0] frame, next_frame, load_pattern;
  logic                 dir, next_dir;
  logic                 pending, state;
  logic                 cfg_wr, wr_ctrl, wr_pat, wr_per, reload;
  logic                 step, take_step, frame_event;
  logic                 unused_wdata;

  assign cfg_wr       = cfg_chipselect & ~cfg_write_n;
  assign wr_ctrl      = cfg_wr && (cfg_address == ADDR_CTRL);
  assign wr_pat       = cfg_wr && (cfg_address == ADDR_PATTERN);
  assign wr_per       = cfg_wr && (cfg_address == ADDR_PERIOD);
  assign reload       = wr_ctrl | wr_pat;
  assign load_pattern = wr_pat ? cfg_writedata[LED_WIDTH-1:0] : pattern;
  assign unused_wdata = ^cfg_writedata;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (reload | wr_per),
    .period (period),
    .step   (step)
  );

  // A config write in the same cycle as a step wins; that step is discarded.
  assign take_step   = step && !(reload | wr_per);
  assign frame_event = reload || (take_step && (next_frame != frame));

  always_comb begin
    next_frame = frame;
    next_dir   = dir;
    case (mode)
      MODE_STATIC: next_frame = pattern;
      MODE_BLINK:  next_frame = (frame == pattern) ? '0 : pattern;
      MODE_CHASE:  next_frame = {frame[LED_WIDTH-2:0], frame[LED_WIDTH-1]};
      default: begin
        // Bounce: an end bit already lit turns around without moving, so a full frame stays put.
        if (!dir) begin
          if (frame[LED_WIDTH-1]) begin
            next_dir = 1'b1;
          end else begin
            next_frame = frame << 1;
            next_dir   = frame[LED_WIDTH-2];
          end
        end else begin
          if (frame[0]) begin
            next_dir = 1'b0;
          end else begin
            next_frame = frame >> 1;
            next_dir   = ~frame[1];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable  <= 1'b0;
      mode    <= MODE_STATIC;
      pattern <= '0;
      period  <= '0;
      frame   <= '0;
      dir     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable <= cfg_writedata[0];
        mode   <= cfg_writedata[2:1];
      end
      if (wr_pat) pattern <= cfg_writedata[LED_WIDTH-1:0];
      if (wr_per) period  <= cfg_writedata[15:0];
      if (reload) begin
        frame <= load_pattern;
        dir   <= 1'b0;
      end else if (take_step) begin
        frame <= next_frame;
        dir   <= next_dir;
      end
    end
  end

  // PIO write: a single-cycle strobe (chipselect=1, write_n=0) with data valid in that cycle;
  // the PIO has no waitrequest, so the write is accepted in the strobe cycle itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pending <= 1'b1;
    end else begin
      state   <= (state == ST_IDLE && (pending || frame_event)) ? ST_WRITE : ST_IDLE;
      pending <= frame_event ? 1'b1 : ((state == ST_WRITE) ? 1'b0 : pending);
    end
  end

  assign dbg_state      = state;
  assign pio_address    = PIO_ADDR;
  assign pio_chipselect = (state == ST_WRITE);
  assign pio_write_n    = ~(state == ST_WRITE);
  assign pio_writedata  = (state == ST_WRITE) ? 32'(frame) : 32'd0;

  always_comb begin
    case (cfg_address)
      ADDR_CTRL:    cfg_readdata = {29'd0, mode, enable};
      ADDR_PATTERN: cfg_readdata = 32'(pattern);
      ADDR_PERIOD:  cfg_readdata = {16'd0, period};
      default: begin
        cfg_readdata = 32'({32'd0, frame} << STAT_FRAME_LSB);
        cfg_readdata[STAT_DIR_BIT]  = dir;
        cfg_readdata[STAT_PEND_BIT] = pending;
      end
    endcase
  end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Directed bench for led_pio_sequencer with a short timebase (TICK_DIV=4) and hand-computed frames.
module tb_led_pio_sequencer;

  localparam int LED_WIDTH = 10;
  localparam int TICK_DIV  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cfg_address = 2'd0;
  logic        cfg_chipselect = 1'b0;
  logic        cfg_write_n = 1'b1;
  logic [31:0] cfg_writedata = 32'd0;
  logic [31:0] cfg_readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        dbg_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_pio_sequencer #(
    .LED_WIDTH (LED_WIDTH),
    .TICK_DIV  (TICK_DIV),
    .PIO_ADDR  (2'd0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_address    (cfg_address),
    .cfg_chipselect (cfg_chipselect),
    .cfg_write_n    (cfg_write_n),
    .cfg_writedata  (cfg_writedata),
    .cfg_readdata   (cfg_readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .dbg_state      (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; the write is sampled on the following posedge.
  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_address    = a;
    cfg_chipselect = 1'b1;
    cfg_write_n    = 1'b0;
    cfg_writedata  = d;
    @(negedge clk);
    cfg_chipselect = 1'b0;
    cfg_write_n    = 1'b1;
    cfg_writedata  = 32'd0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    cfg_address = a;
    #1;
    d = cfg_readdata;
  endtask

  task automatic wait_strobe(input int max_cyc, output logic [31:0] d, output int n);
    d = 'x;
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
        d = pio_writedata;
        n = i;
        break;
      end
    end
  endtask

  task automatic count_strobes(input int cyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) cnt++;
    end
  endtask

  task automatic check_strobe_now(input string tag, input logic [31:0] exp);
    check({tag, "_strobe"}, {31'd0, pio_chipselect & ~pio_write_n}, 32'd1);
    check({tag, "_data"}, pio_writedata, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] e;
    int n, cnt;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", {31'd0, pio_chipselect}, 32'd0);
    check("rst_wn", {31'd0, pio_write_n}, 32'd1);
    check("rst_wd", pio_writedata, 32'd0);
    check("rst_addr", {30'd0, pio_address}, 32'd0);
    read_reg(2'd3, d);
    check("rst_status", d, 32'h0000_0002);
    read_reg(2'd0, d);
    check("rst_ctrl", d, 32'd0);

    // Release: one boot write of frame 0, then silence
    reset = 1'b0;
    wait_strobe(5, d, n);
    check("boot_data", d, 32'd0);
    check("boot_lat", n, 1);
    count_strobes(50, cnt);
    check("boot_quiet", cnt, 0);

    // Chase, PERIOD=2 -> one step every 8 clocks
    cfg_write(2'd2, 32'd2);
    check("per_nostrobe", {31'd0, pio_chipselect}, 32'd0);
    cfg_write(2'd1, 32'h001);
    check_strobe_now("chase_pat", 32'h001);
    @(negedge clk);
    cfg_write(2'd0, 32'd5);
    check_strobe_now("chase_ctrl", 32'h001);
    for (int k = 0; k < 10; k++) begin
      e = 32'h1 << ((k + 1) % 10);
      wait_strobe(20, d, n);
      check($sformatf("chase_%0d", k), d, e);
      check($sformatf("chase_gap_%0d", k), n, 8);
    end

    // Bounce from 0x001: up to 0x200, back down to 0x001, then up again
    @(negedge clk);
    cfg_write(2'd0, 32'd7);
    check_strobe_now("bnc_ctrl", 32'h001);
    for (int k = 1; k <= 9; k++) begin
      wait_strobe(20, d, n);
      check($sformatf("bnc_up_%0d", k), d, 32'h1 << k);
    end
    @(negedge clk);
    read_reg(2'd3, d);
    check("bnc_status_top", d, 32'h0200_0001);
    for (int k = 8; k >= 0; k--) begin
      wait_strobe(20, d, n);
      check($sformatf("bnc_dn_%0d", k), d, 32'h1 << k);
    end
    @(negedge clk);
    read_reg(2'd3, d);
    check("bnc_status_bot", d, 32'h0001_0000);
    wait_strobe(20, d, n);
    check("bnc_again", d, 32'h002);

    // Blink 0x155
    @(negedge clk);
    cfg_write(2'd1, 32'h155);
    check_strobe_now("blk_pat", 32'h155);
    @(negedge clk);
    cfg_write(2'd0, 32'd3);
    check_strobe_now("blk_ctrl", 32'h155);
    wait_strobe(20, d, n);
    check("blk_0", d, 32'h000);
    check("blk_gap_0", n, 8);
    wait_strobe(20, d, n);
    check("blk_1", d, 32'h155);
    check("blk_gap_1", n, 8);
    wait_strobe(20, d, n);
    check("blk_2", d, 32'h000);
    check("blk_gap_2", n, 8);
    // PATTERN write lands on the next step edge: the write wins and the timebase restarts
    repeat (7) @(negedge clk);
    cfg_write(2'd1, 32'h0AA);
    check_strobe_now("blk_collide", 32'h0AA);
    wait_strobe(20, d, n);
    check("blk_after", d, 32'h000);
    check("blk_after_gap", n, 8);

    // Zero pattern in chase: only the load write, then nothing
    @(negedge clk);
    cfg_write(2'd1, 32'h000);
    check_strobe_now("zero_pat", 32'h000);
    @(negedge clk);
    cfg_write(2'd0, 32'd5);
    check_strobe_now("zero_ctrl", 32'h000);
    count_strobes(800, cnt);
    check("zero_quiet", cnt, 0);
    read_reg(2'd3, d);
    check("zero_status", d, 32'd0);
    read_reg(2'd0, d);
    check("rd_ctrl", d, 32'd5);
    read_reg(2'd2, d);
    check("rd_period", d, 32'd2);

    // Reset in the middle of a PIO write
    @(negedge clk);
    cfg_write(2'd1, 32'h3C3);
    check_strobe_now("mid_pat", 32'h3C3);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_cs", {31'd0, pio_chipselect}, 32'd0);
    check("mid_rst_wn", {31'd0, pio_write_n}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_strobe(5, d, n);
    check("post_rst_data", d, 32'd0);
    check("post_rst_lat", n, 1);
    count_strobes(20, cnt);
    check("post_rst_quiet", cnt, 0);
    read_reg(2'd1, d);
    check("post_rst_pattern", d, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
